// File: rtl/fm_stream_reader.sv
// fm_stream_reader: streams a block of words out of a feature-map RAM with a
// fixed registered read latency, presenting them as a valid/ready stream.
// Outstanding reads are credit-limited against a small output FIFO so that
// consumer stalls never drop data.
// Optional: define FM_STREAM_READER_PERF_EN to add the stall_cycles counter.
module fm_stream_reader #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
`ifdef FM_STREAM_READER_PERF_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [PW-1:0]         PTR_ONE  = 1;
   localparam logic [PW:0]           FULL_CNT = (PW+1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < RD_LATENCY + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("fm_stream_reader: FIFO_DEPTH must be a power of 2 and >= RD_LATENCY+2");
   end

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH:0]   len_q, issued, accepted;
   logic [RD_LATENCY:0]   vld_pipe;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           fifo_cnt;
   logic                  issue, fifo_wr, fifo_rd;

   // a tag leaving the last pipe stage means rd_data holds that read's word
   assign fifo_wr = vld_pipe[RD_LATENCY];
   assign fifo_rd = m_valid & m_ready;
   assign m_valid = (fifo_cnt != '0);
   assign m_data  = fifo_mem[rd_ptr];
   assign m_last  = m_valid & (accepted == len_q - CNT_ONE);

   // Issue gate: every in-flight tag plus every FIFO entry surviving this
   // cycle's pop, plus the new read, must fit in the FIFO. Crediting the pop
   // is what lets the pipe sustain one word per cycle with a depth of
   // RD_LATENCY+2.
   always_comb begin
      issue = 1'b0;
      if (state == RUN && issued != len_q &&
          ($countones(vld_pipe) + int'(fifo_cnt) + 1 <= FIFO_DEPTH + int'(fifo_rd)))
         issue = 1'b1;
   end

   // Control FSM: launch, issue bookkeeping, completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_addr   <= '0;
         next_addr <= '0;
         len_q     <= '0;
         issued    <= '0;
         accepted  <= '0;
      end else begin
         done <= 1'b0;
         if (issue) begin
            rd_addr   <= next_addr;
            next_addr <= next_addr + ADDR_ONE;
            issued    <= issued + CNT_ONE;
         end
         if (fifo_rd)
            accepted <= accepted + CNT_ONE;
         case (state)
            IDLE: if (start) begin
               len_q     <= length;
               next_addr <= base_addr;
               issued    <= '0;
               accepted  <= '0;
               if (length == '0) begin
                  done <= 1'b1;
               end else begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: if (issue && (issued + CNT_ONE == len_q))
               state <= FLUSH;
            FLUSH: if (fifo_rd && (accepted + CNT_ONE == len_q)) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-latency tag pipe and output FIFO; storage is cleared so m_data
   // reads zero out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_mem[i] <= '0;
      end else begin
         vld_pipe <= {vld_pipe[RD_LATENCY-1:0], issue};
         if (fifo_wr) begin
            fifo_mem[wr_ptr] <= rd_data;
            wr_ptr           <= wr_ptr + PTR_ONE;
         end
         if (fifo_rd)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({fifo_wr, fifo_rd})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // the credit gate must make a write into a full FIFO impossible
   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_wr && fifo_cnt == FULL_CNT));

`ifdef FM_STREAM_READER_PERF_EN
   // Saturating count of consumer-stall cycles within a transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (state == IDLE && start)
         stall_cycles <= '0;
      else if (busy && m_valid && !m_ready && stall_cycles != 16'hFFFF)
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fm_stream_reader.sv
// Directed bench for fm_stream_reader: a table of transfers run against a
// 2-cycle RAM model with mem[a] = a + 0x100, plus hand-written sequences for
// zero length and mid-transfer reset.
module tb_fm_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic        busy, done;
   logic [9:0]  rd_addr;
   logic [9:0]  rd_data;
   logic [9:0]  m_data;
   logic        m_valid, m_ready, m_last;
`ifdef FM_STREAM_READER_PERF_EN
   logic [15:0] stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fm_stream_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last)
`ifdef FM_STREAM_READER_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   function automatic logic [9:0] ram_val(input logic [9:0] a);
      return a + 10'h100;
   endfunction

   // RAM: address registered at one edge, q valid after the next
   logic [9:0] ram_q1;
   always @(posedge clk) begin
      ram_q1  <= ram_val(rd_addr);
      rd_data <= ram_q1;
   end

   function automatic logic ready_pat(input int mode, input int k);
      case (mode)
         1:       return (k % 4 == 0) || (k % 4 == 3);
         2:       return (k % 3 == 2);
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [9:0]  base;
      logic [10:0] len;
      int          mode;
      int          exp_first;
      int          exp_done;   // 0: done cycle depends on stall pattern
      int          restart_k;  // cycle to pulse a stray start, -1 none
   } vec_t;

   task automatic run_xfer(input int vi, input vec_t v);
      int k, idx, first_k, done_k, stalls, max_cnt;
      logic [9:0] held;
      logic held_v, last_acc, done_seen;
      string p;
      p = $sformatf("v%0d_", vi);
      k = 0; idx = 0; first_k = -1; done_k = -1; stalls = 0; max_cnt = 0;
      held = '0; held_v = 1'b0; last_acc = 1'b0; done_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; base_addr = v.base; length = v.len; m_ready = 1'b0;
      @(posedge clk);
      while (!done_seen && k < 3000) begin
         @(negedge clk);
         start = (k == v.restart_k);
         if (k == v.restart_k) begin
            base_addr = 10'h300;
            length    = 11'd3;
         end
         m_ready = ready_pat(v.mode, k);
         if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
         if (k == 1) chk({p, "rd_addr_first"}, 32'(rd_addr), 32'(v.base));
         if (last_acc) begin
            chk({p, "done_pulse"}, 32'(done), 32'd1);
            chk({p, "busy_end"}, 32'(busy), 32'd0);
            chk({p, "valid_end"}, 32'(m_valid), 32'd0);
`ifdef FM_STREAM_READER_PERF_EN
            chk({p, "stall_cycles"}, 32'(stall_cycles), 32'(stalls));
`endif
            done_seen = 1'b1;
            done_k = k;
         end else begin
            chk({p, "done_early"}, 32'(done), 32'd0);
            chk({p, "busy"}, 32'(busy), 32'd1);
            if (held_v) begin
               chk({p, "hold_valid"}, 32'(m_valid), 32'd1);
               chk({p, "hold_data"}, 32'(m_data), 32'(held));
            end
            if (m_valid && first_k < 0) first_k = k;
            chk({p, "last"}, 32'(m_last), 32'(m_valid && (idx == int'(v.len) - 1)));
            if (m_valid && m_ready) begin
               chk({p, "data"}, 32'(m_data), 32'(ram_val(v.base + 10'(idx))));
               idx++;
               last_acc = (idx == int'(v.len));
            end
            if (busy && m_valid && !m_ready) stalls++;
            held_v = m_valid && !m_ready;
            held   = m_data;
         end
         k++;
      end
      start = 1'b0;
      if (!done_seen) chk({p, "timeout"}, 32'd0, 32'd1);
      chk({p, "word_count"}, 32'(idx), 32'(v.len));
      chk({p, "first_valid_k"}, 32'(first_k), 32'(v.exp_first));
      if (v.exp_done != 0) chk({p, "done_k"}, 32'(done_k), 32'(v.exp_done));
      chk({p, "fifo_max_ok"}, 32'(max_cnt <= 4), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string p);
      chk({p, "busy"},    32'(busy),    32'd0);
      chk({p, "done"},    32'(done),    32'd0);
      chk({p, "m_valid"}, 32'(m_valid), 32'd0);
      chk({p, "m_last"},  32'(m_last),  32'd0);
      chk({p, "rd_addr"}, 32'(rd_addr), 32'd0);
      chk({p, "m_data"},  32'(m_data),  32'd0);
`ifdef FM_STREAM_READER_PERF_EN
      chk({p, "stall"},   32'(stall_cycles), 32'd0);
`endif
   endtask

   vec_t vecs[7];
   logic [9:0] prev_addr;

   initial begin
      vecs[0] = '{10'h010, 11'd8,    0, 4, 12,   -1};
      vecs[1] = '{10'h010, 11'd8,    1, 4, 0,    -1};
      vecs[2] = '{10'h3FE, 11'd4,    0, 4, 8,    -1};
      vecs[3] = '{10'h100, 11'd1,    0, 4, 5,    -1};
      vecs[4] = '{10'h200, 11'd5,    2, 4, 0,    -1};
      vecs[5] = '{10'h020, 11'd6,    1, 4, 0,     2};
      vecs[6] = '{10'h155, 11'd1024, 0, 4, 1028, -1};

      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      #1 chk_reset_outputs("por_");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_xfer(i, vecs[i]);

      // zero-length transfer: immediate done, nothing issued
      @(negedge clk);
      prev_addr = rd_addr;
      start = 1'b1; base_addr = 10'h123; length = 11'd0;
      @(negedge clk);
      start = 1'b0;
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_valid", 32'(m_valid), 32'd0);
      chk("len0_addr", 32'(rd_addr), 32'(prev_addr));
      repeat (4) begin
         @(negedge clk);
         chk("len0_done_after", 32'(done), 32'd0);
         chk("len0_busy_after", 32'(busy), 32'd0);
         chk("len0_valid_after", 32'(m_valid), 32'd0);
         chk("len0_addr_after", 32'(rd_addr), 32'(prev_addr));
      end

      // reset mid-transfer with two reads in flight
      @(negedge clk);
      start = 1'b1; base_addr = 10'h050; length = 11'd8; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1 chk_reset_outputs("midrst_");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("postrst_valid", 32'(m_valid), 32'd0);
         chk("postrst_busy", 32'(busy), 32'd0);
      end
      run_xfer(7, '{10'h000, 11'd2, 0, 4, 6, -1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
